// File: rtl/xor_fold_acc.sv
// XOR-fold accumulator: folds each channel's DATA_W word down to OUT_W bits, either per beat
// or XOR-accumulated across a frame, with a single-entry valid/ready output register.
module xor_fold_acc #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned NCH    = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*OUT_W-1:0]  out_data,
    output logic [CNT_W-1:0]      out_count
);

    localparam int unsigned NFOLD = DATA_W / OUT_W;

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t                 state_q, state_d;
    logic [NCH*OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [NCH*OUT_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]       out_count_q, out_count_d;

    logic [NCH*OUT_W-1:0]   fold_w;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   accept;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    always_comb begin
        fold_w = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            for (int unsigned k = 0; k < NFOLD; k++) begin
                fold_w[c*OUT_W +: OUT_W] ^= in_data[c*DATA_W + k*OUT_W +: OUT_W];
            end
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // ACC is only ever entered in mode 1, so the latched frame mode is implied by the state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!mode || in_last) begin
                        out_data_d  = fold_w;
                        out_count_d = CNT_W'(1);
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d   = fold_w;
                        cnt_d   = CNT_W'(1);
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (in_last) begin
                        out_data_d  = acc_q ^ fold_w;
                        out_count_d = cnt_inc;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        acc_d = acc_q ^ fold_w;
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

endmodule
